// File: rtl/loader_pkg.sv
// Shared definitions for the UART boot loader: FSM state encoding, the frame
// sync byte and the baud-divider computation.
package loader_pkg;

  // Loader frame-parser states.
  typedef enum logic [2:0] {
    S_SYNC,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } load_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Clock cycles per UART bit (integer truncation).
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// UART 8N1 receiver with a 2-flop input synchronizer.
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   rx        in   serial line, idle high, asynchronous to clk
//   byte_vld  out  one-cycle pulse when a byte with a valid stop bit arrives
//   byte_o    out  received byte, valid with byte_vld
//   frm_err   out  one-cycle pulse when the stop bit is sampled low
module uart_rx_8n1 #(
  parameter int unsigned DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_vld,
  output logic [7:0] byte_o,
  output logic       frm_err
);

  localparam int unsigned CNT_W = $clog2(DIV + 1);
  localparam int unsigned HALF  = DIV / 2;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  logic             r_rx_meta, r_rx_sync, r_rx_prev;
  rx_state_t        r_state, w_nxt_state;
  logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
  logic [2:0]       r_bit, w_nxt_bit;
  logic [7:0]       r_shift, w_nxt_shift;
  logic             r_byte_vld, w_nxt_byte_vld;
  logic [7:0]       r_byte, w_nxt_byte;
  logic             r_frm_err, w_nxt_frm_err;
  logic             w_fall;

  // Synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_fall = r_rx_prev & ~r_rx_sync;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= R_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_byte_vld <= 1'b0;
      r_byte     <= '0;
      r_frm_err  <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_cnt      <= w_nxt_cnt;
      r_bit      <= w_nxt_bit;
      r_shift    <= w_nxt_shift;
      r_byte_vld <= w_nxt_byte_vld;
      r_byte     <= w_nxt_byte;
      r_frm_err  <= w_nxt_frm_err;
    end
  end

  // Next-state: start is re-checked at half a bit, data/stop at bit centres.
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_cnt      = r_cnt;
    w_nxt_bit      = r_bit;
    w_nxt_shift    = r_shift;
    w_nxt_byte_vld = 1'b0;
    w_nxt_byte     = r_byte;
    w_nxt_frm_err  = 1'b0;
    case (r_state)
      R_IDLE: begin
        w_nxt_cnt = '0;
        if (w_fall) w_nxt_state = R_START;
      end
      R_START: begin
        if (r_cnt == CNT_W'(HALF - 1)) begin
          w_nxt_cnt = '0;
          w_nxt_bit = '0;
          // A line already back high was a glitch.
          w_nxt_state = r_rx_sync ? R_IDLE : R_DATA;
        end else begin
          w_nxt_cnt = r_cnt + CNT_W'(1);
        end
      end
      R_DATA: begin
        if (r_cnt == CNT_W'(DIV - 1)) begin
          w_nxt_cnt   = '0;
          w_nxt_shift = {r_rx_sync, r_shift[7:1]};
          if (r_bit == 3'd7) w_nxt_state = R_STOP;
          else               w_nxt_bit   = r_bit + 3'd1;
        end else begin
          w_nxt_cnt = r_cnt + CNT_W'(1);
        end
      end
      R_STOP: begin
        if (r_cnt == CNT_W'(DIV - 1)) begin
          w_nxt_cnt   = '0;
          w_nxt_state = R_IDLE;
          if (r_rx_sync) begin
            w_nxt_byte_vld = 1'b1;
            w_nxt_byte     = r_shift;
          end else begin
            w_nxt_frm_err = 1'b1;
          end
        end else begin
          w_nxt_cnt = r_cnt + CNT_W'(1);
        end
      end
      default: w_nxt_state = R_IDLE;
    endcase
  end

  assign byte_vld = r_byte_vld;
  assign byte_o   = r_byte;
  assign frm_err  = r_frm_err;

endmodule

// File: rtl/rom_uart_loader.sv
// Boot loader: receives a framed program image over UART 8N1 and writes it
// as 32-bit little-endian words into the instruction ROM, holding the core in
// reset until the image is accepted.
// Frame: A5 | LEN lo | LEN hi | LEN x 4 data bytes | [CSUM]
// Build option: define LOADER_CHECKSUM_EN to expect a trailing XOR checksum
// byte covering every byte after the sync byte.
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   uart_rx     in   serial input, idle high
//   rom_we      out  one-cycle ROM write strobe per word
//   rom_waddr   out  ROM word address
//   rom_wdata   out  ROM write data
//   core_rst_n  out  active-low core reset, released after a good load
//   load_done   out  image accepted (sticky until rst)
//   load_err    out  frame rejected (sticky until rst)
module rom_uart_loader
  import loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_waddr,
  output logic [31:0]       rom_wdata,
  output logic              core_rst_n,
  output logic              load_done,
  output logic              load_err
);

  localparam int unsigned DIV   = calc_div(CLK_FREQ, BAUD);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

`ifdef LOADER_CHECKSUM_EN
  localparam load_state_t S_TAIL = S_CSUM;
`else
  localparam load_state_t S_TAIL = S_DONE;
`endif

  logic        w_byte_vld;
  logic [7:0]  w_byte;
  logic        w_frm_err;

  uart_rx_8n1 #(.DIV(DIV)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx       (uart_rx),
    .byte_vld (w_byte_vld),
    .byte_o   (w_byte),
    .frm_err  (w_frm_err)
  );

  load_state_t       r_state, w_nxt_state;
  logic [15:0]       r_len, w_nxt_len;
  logic [ADDR_W-1:0] r_idx, w_nxt_idx;
  logic [23:0]       r_word, w_nxt_word;
  logic [1:0]        r_bcnt, w_nxt_bcnt;
  logic [TMO_W-1:0]  r_tmo, w_nxt_tmo;
  logic              r_rom_we, w_nxt_rom_we;
  logic [ADDR_W-1:0] r_rom_waddr, w_nxt_rom_waddr;
  logic [31:0]       r_rom_wdata, w_nxt_rom_wdata;
  logic              r_core_rst_n, w_nxt_core_rst_n;
  logic              r_load_done, w_nxt_load_done;
  logic              r_load_err, w_nxt_load_err;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        r_csum, w_nxt_csum;
`endif

  logic [15:0] w_len_full;
  logic [31:0] w_word_full;
  logic        w_last_word;
  logic        w_active;

  assign w_len_full  = {w_byte, r_len[7:0]};
  assign w_word_full = {w_byte, r_word};
  assign w_last_word = (32'(r_idx) + 32'd1) == 32'(r_len);
  assign w_active    = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                       (r_state == S_DATA) || (r_state == S_CSUM);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_SYNC;
      r_len        <= '0;
      r_idx        <= '0;
      r_word       <= '0;
      r_bcnt       <= '0;
      r_tmo        <= '0;
      r_rom_we     <= 1'b0;
      r_rom_waddr  <= '0;
      r_rom_wdata  <= '0;
      r_core_rst_n <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      r_state      <= w_nxt_state;
      r_len        <= w_nxt_len;
      r_idx        <= w_nxt_idx;
      r_word       <= w_nxt_word;
      r_bcnt       <= w_nxt_bcnt;
      r_tmo        <= w_nxt_tmo;
      r_rom_we     <= w_nxt_rom_we;
      r_rom_waddr  <= w_nxt_rom_waddr;
      r_rom_wdata  <= w_nxt_rom_wdata;
      r_core_rst_n <= w_nxt_core_rst_n;
      r_load_done  <= w_nxt_load_done;
      r_load_err   <= w_nxt_load_err;
`ifdef LOADER_CHECKSUM_EN
      r_csum       <= w_nxt_csum;
`endif
    end
  end

  // Frame parser, word assembler, timeout and status outputs.
  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_len        = r_len;
    w_nxt_idx        = r_idx;
    w_nxt_word       = r_word;
    w_nxt_bcnt       = r_bcnt;
    w_nxt_rom_we     = 1'b0;
    w_nxt_rom_waddr  = r_rom_waddr;
    w_nxt_rom_wdata  = r_rom_wdata;
    // Status follows the terminal state one cycle later, so the final rom_we
    // pulse has already dropped when core_rst_n rises.
    w_nxt_core_rst_n = (r_state == S_DONE);
    w_nxt_load_done  = (r_state == S_DONE);
    w_nxt_load_err   = (r_state == S_ERR);
    w_nxt_tmo        = (!w_active || w_byte_vld) ? '0 : r_tmo + TMO_W'(1);
`ifdef LOADER_CHECKSUM_EN
    w_nxt_csum       = r_csum;
    if (w_byte_vld && ((r_state == S_LEN0) || (r_state == S_LEN1) || (r_state == S_DATA)))
      w_nxt_csum = r_csum ^ w_byte;
`endif

    case (r_state)
      S_SYNC: begin
`ifdef LOADER_CHECKSUM_EN
        w_nxt_csum = '0;
`endif
        if (w_byte_vld && (w_byte == SYNC_BYTE)) w_nxt_state = S_LEN0;
      end
      S_LEN0: begin
        if (w_byte_vld) begin
          w_nxt_len   = {8'h00, w_byte};
          w_nxt_state = S_LEN1;
        end
      end
      S_LEN1: begin
        if (w_byte_vld) begin
          w_nxt_len  = w_len_full;
          w_nxt_idx  = '0;
          w_nxt_bcnt = '0;
          if (32'(w_len_full) > DEPTH)  w_nxt_state = S_ERR;
          else if (w_len_full == 16'd0) w_nxt_state = S_TAIL;
          else                          w_nxt_state = S_DATA;
        end
      end
      S_DATA: begin
        if (w_byte_vld) begin
          w_nxt_word = w_word_full[31:8];
          w_nxt_bcnt = r_bcnt + 2'd1;
          if (r_bcnt == 2'd3) begin
            w_nxt_rom_we    = 1'b1;
            w_nxt_rom_waddr = r_idx;
            w_nxt_rom_wdata = w_word_full;
            // Index never advances past the last word, so it cannot wrap.
            if (w_last_word) w_nxt_state = S_TAIL;
            else             w_nxt_idx   = r_idx + ADDR_W'(1);
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (w_byte_vld) w_nxt_state = (w_byte == r_csum) ? S_DONE : S_ERR;
      end
`endif
      default: ;
    endcase

    // Framing errors and inter-byte timeout abort an in-progress frame.
    if (w_active && w_frm_err) w_nxt_state = S_ERR;
    if (w_active && !w_byte_vld && (r_tmo >= TMO_W'(TIMEOUT_CYC))) w_nxt_state = S_ERR;
  end

  assign rom_we     = r_rom_we;
  assign rom_waddr  = r_rom_waddr;
  assign rom_wdata  = r_rom_wdata;
  assign core_rst_n = r_core_rst_n;
  assign load_done  = r_load_done;
  assign load_err   = r_load_err;

endmodule

// File: tb/tb_rom_uart_loader.sv
// Directed bench for rom_uart_loader. The UART runs at 16 clocks per bit and
// the inter-byte timeout is 2000 cycles to keep the run short; frame contents
// match the reference sequences. Honours LOADER_CHECKSUM_EN when defined.
module tb_rom_uart_loader;

  localparam int unsigned CLK_HZ  = 50_000_000;
  localparam int unsigned BIT_CYC = 16;
  localparam int unsigned TMO     = 2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic        rom_we;
  logic [11:0] rom_waddr;
  logic [31:0] rom_wdata;
  logic        core_rst_n;
  logic        load_done;
  logic        load_err;

  int n_tests = 0;
  int n_fail  = 0;

  int          wr_n = 0;
  int          overlap_n = 0;
  logic [11:0] wr_addr [64];
  logic [31:0] wr_data [64];
  logic [7:0]  tx_q [$];
  int          base;

  always #10 clk = ~clk;

  rom_uart_loader #(
    .CLK_FREQ    (CLK_HZ),
    .BAUD        (CLK_HZ / BIT_CYC),
    .ADDR_W      (12),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_rx    (uart_rx),
    .rom_we     (rom_we),
    .rom_waddr  (rom_waddr),
    .rom_wdata  (rom_wdata),
    .core_rst_n (core_rst_n),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  // ROM write logger, sampled away from the active edge.
  always @(negedge clk) begin
    if (rom_we) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] = rom_waddr;
        wr_data[wr_n] = rom_wdata;
      end
      wr_n = wr_n + 1;
      if (core_rst_n) overlap_n = overlap_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    uart_rx = stop;
    repeat (BIT_CYC) @(negedge clk);
    uart_rx = 1'b1;
    repeat (BIT_CYC) @(negedge clk);
  endtask

  task automatic send_q();
    foreach (tx_q[i]) send_byte(tx_q[i], 1'b1);
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic load_frame1();
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    tx_q.push_back(8'h7E);
`endif
  endtask

  initial begin
    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_we", 32'(rom_we), 32'd0);
    chk("rst_waddr", 32'(rom_waddr), 32'd0);
    chk("rst_wdata", rom_wdata, 32'd0);
    chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);

    // 1: two-word image.
    do_reset();
    base = wr_n;
    load_frame1();
    send_q();
    chk("t1_nwr", 32'(wr_n - base), 32'd2);
    chk("t1_a0", 32'(wr_addr[base]), 32'd0);
    chk("t1_d0", wr_data[base], 32'h0000_0013);
    chk("t1_a1", 32'(wr_addr[base+1]), 32'd1);
    chk("t1_d1", wr_data[base+1], 32'h0000_006F);
    chk("t1_done", 32'(load_done), 32'd1);
    chk("t1_core", 32'(core_rst_n), 32'd1);
    chk("t1_err", 32'(load_err), 32'd0);
    // Bytes after DONE are ignored.
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_q();
    chk("t1_post_nwr", 32'(wr_n - base), 32'd2);
    chk("t1_post_done", 32'(load_done), 32'd1);

    // 2: leading garbage, single word.
    do_reset();
    base = wr_n;
    tx_q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef LOADER_CHECKSUM_EN
    tx_q.push_back(8'h23);
`endif
    send_q();
    chk("t2_nwr", 32'(wr_n - base), 32'd1);
    chk("t2_a0", 32'(wr_addr[base]), 32'd0);
    chk("t2_d0", wr_data[base], 32'hDEAD_BEEF);
    chk("t2_done", 32'(load_done), 32'd1);

    // 3: LEN = 0x1001 exceeds the 4096-word ROM.
    do_reset();
    base = wr_n;
    tx_q = '{8'hA5, 8'h01, 8'h10};
    send_q();
    chk("t3_nwr", 32'(wr_n - base), 32'd0);
    chk("t3_err", 32'(load_err), 32'd1);
    chk("t3_core", 32'(core_rst_n), 32'd0);
    chk("t3_done", 32'(load_done), 32'd0);

    // 4: inter-byte timeout in the middle of a word.
    do_reset();
    base = wr_n;
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE};
    send_q();
    repeat (100) @(negedge clk);
    chk("t4_err_early", 32'(load_err), 32'd0);
    repeat (TMO + 10) @(negedge clk);
    chk("t4_err", 32'(load_err), 32'd1);
    tx_q = '{8'hAD, 8'hDE};
    send_q();
    chk("t4_nwr", 32'(wr_n - base), 32'd0);
    chk("t4_err_hold", 32'(load_err), 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // 5: bad checksum after both words.
    do_reset();
    base = wr_n;
    load_frame1();
    tx_q[tx_q.size()-1] = 8'h00;
    send_q();
    chk("t5_nwr", 32'(wr_n - base), 32'd2);
    chk("t5_err", 32'(load_err), 32'd1);
    chk("t5_done", 32'(load_done), 32'd0);
    chk("t5_core", 32'(core_rst_n), 32'd0);
`endif

    // 6: reset mid-word, then full reload from address 0.
    do_reset();
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00};
    send_q();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_rst_wdata", rom_wdata, 32'd0);
    chk("t6_rst_core", 32'(core_rst_n), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    base = wr_n;
    load_frame1();
    send_q();
    chk("t6_nwr", 32'(wr_n - base), 32'd2);
    chk("t6_a0", 32'(wr_addr[base]), 32'd0);
    chk("t6_d0", wr_data[base], 32'h0000_0013);
    chk("t6_a1", 32'(wr_addr[base+1]), 32'd1);
    chk("t6_d1", wr_data[base+1], 32'h0000_006F);
    chk("t6_done", 32'(load_done), 32'd1);

    // 7: stop bit low inside the data phase.
    do_reset();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hEF, 1'b0);
    repeat (BIT_CYC * 2) @(negedge clk);
    chk("t7_err", 32'(load_err), 32'd1);
    chk("t7_done", 32'(load_done), 32'd0);

    // 8: 100 ns idle-line glitch while waiting for LEN lo must not form a byte.
    do_reset();
    base = wr_n;
    send_byte(8'hA5, 1'b1);
    uart_rx = 1'b0;
    #100;
    uart_rx = 1'b1;
    repeat (BIT_CYC * 20) @(negedge clk);
    tx_q = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef LOADER_CHECKSUM_EN
    tx_q.push_back(8'h45);
`endif
    send_q();
    chk("t8_nwr", 32'(wr_n - base), 32'd1);
    chk("t8_d0", wr_data[base], 32'h4433_2211);
    chk("t8_done", 32'(load_done), 32'd1);
    chk("t8_err", 32'(load_err), 32'd0);

    // rom_we never seen while the core is out of reset.
    chk("we_core_overlap", 32'(overlap_n), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
